// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     state_e    - controller state encodings (IDLE=0, RUN=1, DONE=2)
//     cnt_width  - constant function sizing the bit counter so it can hold
//                  WIDTH-1, never narrower than one bit
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // $clog2(1) is 0, which would give a zero-width counter for WIDTH=1.
  function automatic int cnt_width(input int width);
    if (width <= 2) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full-adder cell, reused unchanged by serial_adder.
//   Ports:
//     A, B  - operand bits
//     Cin   - carry in
//     Sum   - A ^ B ^ Cin
//     Cout  - majority(A, B, Cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: one full-adder cell processes one operand bit pair per
//   clock, LSB first, with the carry held in a flop. Produces
//   {cout,sum} = a + b + cin after WIDTH cycles.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     start  - load a/b/cin and begin; honoured only when not busy
//     a, b   - WIDTH-bit operands, captured on the accepting edge
//     cin    - carry in, captured on the accepting edge
//     busy   - high while bits are being processed
//     done   - one-cycle pulse when sum/cout hold a new result
//     sum    - WIDTH-bit result, held until the next result
//     cout   - carry out of the MSB, held until the next result
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // sum bits collected so far, MSB-first fill
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the
        // result has travelled down to acc[0].
        acc_d           = acc_q >> 1;
        acc_d[WIDTH-1]  = fa_sum;
        sa_d            = sa_q >> 1;
        sb_d            = sb_q >> 1;
        carry_d         = fa_cout;
        cnt_d           = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, datapath and output registers are reset so an aborted
  // operation leaves nothing stale behind and sum/cout read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Drives an 8-bit and a 1-bit serial_adder. Stimulus tasks push the expected
//   {cout,sum} (plain a+b+cin) and the accept cycle into per-instance queues;
//   a monitor checks results, latency, busy length and output hold behaviour.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  typedef struct {
    logic [8:0] res;
    int         acc;
  } exp_t;

  exp_t       q8[$];
  exp_t       q1[$];
  logic [8:0] held [2];
  int         busy_cnt [2];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic mon_port(input int id, input int w, input logic bsy, input logic dn,
                          input logic [8:0] res);
    exp_t e;
    int   qs;
    check($sformatf("busy_done_excl[w%0d]", w), 32'(bsy & dn), 0);
    if (bsy) busy_cnt[id]++;
    if (dn) begin
      qs = (id == 0) ? q8.size() : q1.size();
      check($sformatf("done_expected[w%0d]", w), 32'(qs != 0), 1);
      if (qs != 0) begin
        e = (id == 0) ? q8.pop_front() : q1.pop_front();
        check($sformatf("result[w%0d]", w), 32'(res), 32'(e.res));
        check($sformatf("latency[w%0d]", w), cyc - e.acc, w);
        check($sformatf("busy_cycles[w%0d]", w), busy_cnt[id], w);
        held[id] = e.res;
      end
      busy_cnt[id] = 0;
    end
    check($sformatf("hold[w%0d]", w), 32'(res), 32'(held[id]));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      mon_port(0, 8, busy8, done8, {cout8, sum8});
      mon_port(1, 1, busy1, done1, {7'b0, cout1, sum1});
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    check("wait_idle8", 32'(busy8), 0);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int acc);
    @(negedge clk);
    wait_idle8();
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    acc = cyc;
    q8.push_back('{res: {1'b0, a} + {1'b0, b} + 9'(c), acc: cyc});
    start8 = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic c);
    int n = 0;
    @(negedge clk);
    while (busy1 && n < 100) begin @(negedge clk); n++; end
    check("wait_idle1", 32'(busy1), 0);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(posedge clk); #1;
    q1.push_back('{res: 9'(a) + 9'(b) + 9'(c), acc: cyc});
    start1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, n;
    held     = '{9'd0, 9'd0};
    busy_cnt = '{0, 0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_sum",  32'(sum8),  0);
    check("rst_cout", 32'(cout8), 0);
    check("rst_busy1", 32'(busy1), 0);
    rst_n = 1'b1;

    // Directed cases
    issue8(8'h5A, 8'h3C, 1'b0, acc0);
    issue8(8'hFF, 8'h01, 1'b0, acc0);
    issue8(8'hFF, 8'hFF, 1'b1, acc0);
    issue8(8'h00, 8'h00, 1'b0, acc0);

    // start during RUN is ignored
    issue8(8'h12, 8'h34, 1'b1, acc0);
    repeat (3) @(negedge clk);
    check("busy_at_ignored_start", 32'(busy8), 1);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;

    // Asynchronous reset mid-RUN
    issue8(8'h77, 8'h19, 1'b0, acc0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_sum",  32'(sum8),  0);
    check("abort_cout", 32'(cout8), 0);
    q8.delete();
    q1.delete();
    held     = '{9'd0, 9'd0};
    busy_cnt = '{0, 0};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);   // any stray done is flagged by the monitor
    issue8(8'h0F, 8'h01, 1'b0, acc0);

    // Back-to-back: start held through DONE with new operands
    @(negedge clk);
    wait_idle8();
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1;
    @(posedge clk); #1;
    acc0 = cyc;
    q8.push_back('{res: 9'h0C3 + 9'h05A + 9'd1, acc: cyc});
    a8 = 8'h81; b8 = 8'h7F; cin8 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 20);
    check("b2b_done_seen", 32'(done8), 1);
    @(posedge clk); #1;
    acc1 = cyc;
    q8.push_back('{res: 9'h081 + 9'h07F, acc: cyc});
    check("b2b_gap", acc1 - acc0, 9);
    start8 = 1'b0;

    // Random operands
    for (int i = 0; i < 40; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom), acc0);

    // WIDTH=1: full truth table, then a few random
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      issue1(v[2], v[1], v[0]);
    end
    for (int i = 0; i < 10; i++)
      issue1(1'($urandom), 1'($urandom), 1'($urandom));

    // Drain
    n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("drain_q8", q8.size(), 0);
    check("drain_q1", q1.size(), 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
